la_cmd_sequencer: RTL and testbench

- Command-and-control sequencer between the host UART FIFOs (uart_rx6/uart_tx6) and the logic-analyzer core.
- Assembles 9-byte command packets, updates the trigger and buffer config registers, and issues control pulses.
- Returns 8-byte read responses over the UART TX FIFO.
- Hands off trace readout to the external trace streamer and waits for it to finish.

---
 rtl/la_cmd_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_la_cmd_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_cmd_sequencer.sv
// Host command sequencer for the logic analyzer: assembles 9-byte UART packets,
// updates config registers, issues control pulses and returns 8-byte responses.
module la_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [63:0] TRIG_CFG_RST   = 64'h0,
    parameter logic [63:0] BUFF_CFG_RST   = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_present,
    output logic        rx_read,
    output logic [7:0]  tx_data,
    output logic        tx_write,
    input  logic        tx_full,
    output logic [63:0] trig_cfg,
    output logic [63:0] buff_cfg,
    input  logic [63:0] trace_size,
    input  logic [63:0] trig_sample,
    output logic        start_pulse,
    output logic        abort_pulse,
    output logic        logcap_reset_pulse,
    output logic        trace_read_pulse,
    input  logic        trace_done,
    output logic        busy,
    output logic        cmd_error
);

    localparam int unsigned TW =
        (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_RX,
        S_EXEC,
        S_TX,
        S_TRACE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    opcode;
    logic [63:0]   payload;
    logic [63:0]   resp;
    logic [2:0]    tx_cnt;
    logic          rd_prev;
    logic          tx_prev;

    logic          tmo_hit;
    logic          ex_start;
    logic          ex_abort;
    logic          ex_lcr;
    logic          ex_trace;
    logic          ex_err;
    logic          ex_trig_wr;
    logic          ex_buff_wr;
    logic          ex_resp_ld;
    logic [63:0]   ex_resp_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RX;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rx_read     = 1'b0;
        tx_write    = 1'b0;
        tmo_hit     = 1'b0;
        ex_start    = 1'b0;
        ex_abort    = 1'b0;
        ex_lcr      = 1'b0;
        ex_trace    = 1'b0;
        ex_err      = 1'b0;
        ex_trig_wr  = 1'b0;
        ex_buff_wr  = 1'b0;
        ex_resp_ld  = 1'b0;
        ex_resp_val = 64'h0;
        case (state)
            S_RX: begin
                tmo_hit = (byte_cnt != 4'd0) && (tmo_cnt == TMO_MAX);
                // FIFO flag lags one cycle, so never read back-to-back
                rx_read = rx_data_present && !rd_prev && !tmo_hit;
                if (rx_read && byte_cnt == 4'd8) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = S_RX;
                case (opcode)
                    8'h01: ex_start   = 1'b1;
                    8'h02: ex_abort   = 1'b1;
                    8'h03: ex_trig_wr = 1'b1;
                    8'h04: ex_buff_wr = 1'b1;
                    8'h09: ex_lcr     = 1'b1;
                    8'h05: begin
                        ex_trace  = 1'b1;
                        state_nxt = S_TRACE;
                    end
                    8'h06: begin
                        ex_resp_ld  = 1'b1;
                        ex_resp_val = trace_size;
                        state_nxt   = S_TX;
                    end
                    8'h07: begin
                        ex_resp_ld  = 1'b1;
                        ex_resp_val = trig_sample;
                        state_nxt   = S_TX;
                    end
                    8'h0A: begin
                        ex_resp_ld  = 1'b1;
                        ex_resp_val = buff_cfg;
                        state_nxt   = S_TX;
                    end
                    8'h0B: begin
                        ex_resp_ld  = 1'b1;
                        ex_resp_val = trig_cfg;
                        state_nxt   = S_TX;
                    end
                    default: ex_err = 1'b1;
                endcase
            end
            S_TX: begin
                tx_write = !tx_full && !tx_prev;
                if (tx_write && tx_cnt == 3'd7) begin
                    state_nxt = S_RX;
                end
            end
            S_TRACE: begin
                if (trace_done) begin
                    state_nxt = S_RX;
                end
            end
            default: state_nxt = S_RX;
        endcase
        if (reset) begin
            rx_read  = 1'b0;
            tx_write = 1'b0;
        end
    end

    assign tx_data = tx_write ? resp[7:0] : 8'h00;
    assign busy    = !(state == S_RX && byte_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt           <= 4'd0;
            tmo_cnt            <= '0;
            opcode             <= 8'h00;
            payload            <= 64'h0;
            resp               <= 64'h0;
            tx_cnt             <= 3'd0;
            rd_prev            <= 1'b0;
            tx_prev            <= 1'b0;
            trig_cfg           <= TRIG_CFG_RST;
            buff_cfg           <= BUFF_CFG_RST;
            start_pulse        <= 1'b0;
            abort_pulse        <= 1'b0;
            logcap_reset_pulse <= 1'b0;
            trace_read_pulse   <= 1'b0;
            cmd_error          <= 1'b0;
        end else begin
            rd_prev            <= rx_read;
            tx_prev            <= tx_write;
            start_pulse        <= ex_start;
            abort_pulse        <= ex_abort;
            logcap_reset_pulse <= ex_lcr;
            trace_read_pulse   <= ex_trace;
            cmd_error          <= ex_err | tmo_hit;

            if (rx_read) begin
                tmo_cnt <= '0;
                if (byte_cnt == 4'd0) begin
                    opcode <= rx_data;
                end else begin
                    payload <= {rx_data, payload[63:8]};
                end
                byte_cnt <= (byte_cnt == 4'd8) ? 4'd0 : byte_cnt + 4'd1;
            end else if (tmo_hit) begin
                byte_cnt <= 4'd0;
                tmo_cnt  <= '0;
            end else if (state == S_RX && byte_cnt != 4'd0) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (ex_trig_wr) begin
                trig_cfg <= payload;
            end
            if (ex_buff_wr) begin
                buff_cfg <= payload;
            end
            // Response shifts out LSB first
            if (ex_resp_ld) begin
                resp   <= ex_resp_val;
                tx_cnt <= 3'd0;
            end else if (tx_write) begin
                resp   <= {8'h00, resp[63:8]};
                tx_cnt <= tx_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_la_cmd_sequencer.sv
// Scoreboard bench for la_cmd_sequencer: RX FIFO model, TX byte queue,
// pulse counters and config register model.
module tb_la_cmd_sequencer;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_present = 1'b0;
    logic        rx_read;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_full = 1'b0;
    logic [63:0] trig_cfg;
    logic [63:0] buff_cfg;
    logic [63:0] trace_size = 64'hDEAD_BEEF_0BAD_F00D;
    logic [63:0] trig_sample = 64'h1122_3344_5566_7788;
    logic        start_pulse;
    logic        abort_pulse;
    logic        logcap_reset_pulse;
    logic        trace_read_pulse;
    logic        trace_done = 1'b0;
    logic        busy;
    logic        cmd_error;

    la_cmd_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .TRIG_CFG_RST(64'h0),
        .BUFF_CFG_RST(64'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_data_present(rx_data_present),
        .rx_read(rx_read),
        .tx_data(tx_data),
        .tx_write(tx_write),
        .tx_full(tx_full),
        .trig_cfg(trig_cfg),
        .buff_cfg(buff_cfg),
        .trace_size(trace_size),
        .trig_sample(trig_sample),
        .start_pulse(start_pulse),
        .abort_pulse(abort_pulse),
        .logcap_reset_pulse(logcap_reset_pulse),
        .trace_read_pulse(trace_read_pulse),
        .trace_done(trace_done),
        .busy(busy),
        .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txw = 0, n_start = 0, n_abort = 0, n_lcr = 0, n_trace = 0, n_err = 0;
    int cyc = 0, start_cyc = 0, abort_cyc = 0;
    logic start_q = 1'b0, abort_q = 1'b0, err_q = 1'b0;
    logic rd_seen = 1'b0;
    logic in_trace = 1'b0;
    logic [7:0] rxq[$];
    logic [7:0] exp_tx[$];
    logic [63:0] m_trig = 64'h0;
    logic [63:0] m_buff = 64'h0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        rx_data_present = (rxq.size() != 0);
        rx_data = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    task automatic push_pkt(input logic [7:0] op, input logic [63:0] pl);
        rxq.push_back(op);
        for (int i = 0; i < 8; i++) rxq.push_back(pl[8*i +: 8]);
        refresh();
    endtask

    task automatic expect_resp(input logic [63:0] v);
        for (int i = 0; i < 8; i++) exp_tx.push_back(v[8*i +: 8]);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rxq.size() == 0 && !busy && exp_tx.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done)
            chk("idle_timeout", 64'(rxq.size() + exp_tx.size()), 0);
        step(1);
    endtask

    // FIFO pop lands just after the edge on which the DUT captured the head
    always @(posedge clk) begin
        #1;
        if (rd_seen && rxq.size() > 0) begin
            void'(rxq.pop_front());
            refresh();
        end
    end

    always @(negedge clk) begin
        cyc++;
        rd_seen = rx_read;
        if (!reset) begin
            if (tx_write) begin
                n_txw++;
                chk("tx_full_hold", 64'(tx_full), 0);
                if (exp_tx.size() != 0) chk("tx_data", 64'(tx_data), 64'(exp_tx.pop_front()));
                else chk("tx_extra", 64'(tx_write), 0);
            end
            if (start_pulse) begin
                n_start++;
                start_cyc = cyc;
                chk("start_width", 64'(start_q), 0);
            end
            if (abort_pulse) begin
                n_abort++;
                abort_cyc = cyc;
                chk("abort_width", 64'(abort_q), 0);
            end
            if (cmd_error) begin
                n_err++;
                chk("err_width", 64'(err_q), 0);
            end
            if (logcap_reset_pulse) n_lcr++;
            if (trace_read_pulse) n_trace++;
            if (in_trace) chk("rx_in_trace", 64'(rx_read), 0);
        end
        start_q = start_pulse;
        abort_q = abort_pulse;
        err_q   = cmd_error;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2;
        bit seen;
        step(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_trig_cfg", trig_cfg, 64'h0);
        chk("rst_buff_cfg", buff_cfg, 64'h0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_cmd_error", 64'(cmd_error), 0);
        chk("rst_start", 64'(start_pulse), 0);
        chk("rst_tx_write", 64'(tx_write), 0);
        chk("rst_rx_read", 64'(rx_read), 0);
        step(1);

        // trig_cfg write
        t0 = n_txw;
        push_pkt(8'h03, 64'h55);
        m_trig = 64'h55;
        wait_idle(100);
        chk("trig_wr", trig_cfg, m_trig);
        chk("trig_wr_no_tx", 64'(n_txw - t0), 0);
        chk("trig_wr_busy", 64'(busy), 0);

        // write-then-read
        t0 = n_txw;
        push_pkt(8'h0B, 64'h0);
        expect_resp(m_trig);
        wait_idle(100);
        chk("rd_trig_count", 64'(n_txw - t0), 8);
        chk("rd_trig_keep", trig_cfg, m_trig);

        // start then abort
        t0 = n_start;
        t1 = n_abort;
        push_pkt(8'h01, 64'h0);
        push_pkt(8'h02, 64'h0);
        wait_idle(200);
        chk("start_count", 64'(n_start - t0), 1);
        chk("abort_count", 64'(n_abort - t1), 1);
        chk("start_before_abort", 64'(abort_cyc > start_cyc), 1);
        chk("sa_trig", trig_cfg, m_trig);
        chk("sa_buff", buff_cfg, m_buff);

        // partial packet timeout
        t0 = n_err;
        rxq.push_back(8'h04);
        rxq.push_back(8'hAA);
        rxq.push_back(8'hBB);
        refresh();
        step(TMO + 30);
        chk("tmo_err", 64'(n_err - t0), 1);
        chk("tmo_buff", buff_cfg, m_buff);
        chk("tmo_busy", 64'(busy), 0);
        push_pkt(8'h04, 64'h0123456789ABCDEF);
        m_buff = 64'h0123456789ABCDEF;
        wait_idle(100);
        chk("buff_wr", buff_cfg, m_buff);

        // tx_full stall
        tx_full = 1'b1;
        t0 = n_txw;
        push_pkt(8'h0B, 64'h0);
        expect_resp(m_trig);
        step(50);
        chk("tx_stall", 64'(n_txw - t0), 0);
        tx_full = 1'b0;
        wait_idle(100);
        chk("tx_release", 64'(n_txw - t0), 8);

        // trace handoff with a queued read behind it
        t0 = n_trace;
        t1 = n_txw;
        push_pkt(8'h05, 64'h0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_trace != t0) begin
                seen = 1;
                break;
            end
        end
        step(1);
        chk("trace_pulse", 64'(n_trace - t0), 1);
        in_trace = 1'b1;
        push_pkt(8'h0A, 64'h0);
        expect_resp(m_buff);
        step(200);
        chk("trace_rx_queued", 64'(rxq.size()), 9);
        chk("trace_no_tx", 64'(n_txw - t1), 0);
        trace_done = 1'b1;
        in_trace = 1'b0;
        step(1);
        trace_done = 1'b0;
        wait_idle(100);
        chk("trace_resp", 64'(n_txw - t1), 8);

        // trace_size, trig_sample reads and logcap reset
        t0 = n_txw;
        t1 = n_lcr;
        push_pkt(8'h06, 64'hFFFF);
        expect_resp(trace_size);
        push_pkt(8'h07, 64'h0);
        expect_resp(trig_sample);
        push_pkt(8'h09, 64'h0);
        wait_idle(300);
        chk("rd_size_sample", 64'(n_txw - t0), 16);
        chk("lcr_count", 64'(n_lcr - t1), 1);

        // unknown opcode
        t0 = n_err;
        t1 = n_txw;
        t2 = n_start + n_abort + n_lcr + n_trace;
        push_pkt(8'h7E, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle(100);
        chk("bad_op_err", 64'(n_err - t0), 1);
        chk("bad_op_trig", trig_cfg, m_trig);
        chk("bad_op_buff", buff_cfg, m_buff);
        chk("bad_op_tx", 64'(n_txw - t1), 0);
        chk("bad_op_pulses", 64'(n_start + n_abort + n_lcr + n_trace - t2), 0);

        // reset while a response is stalled
        tx_full = 1'b1;
        t0 = n_txw;
        push_pkt(8'h0B, 64'h0);
        step(40);
        chk("mid_resp_busy", 64'(busy), 1);
        exp_tx.delete();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        tx_full = 1'b0;
        m_trig = 64'h0;
        m_buff = 64'h0;
        step(30);
        chk("post_rst_tx", 64'(n_txw - t0), 0);
        chk("post_rst_trig", trig_cfg, m_trig);
        chk("post_rst_buff", buff_cfg, m_buff);
        chk("post_rst_busy", 64'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
